// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage for the 16-bit core.
// Owns the fetch PC, issues word reads to instruction memory, buffers the
// returned words with their PCs in a prefetch FIFO and hands them to the core.
// A redirect restarts fetch and discards responses still in flight.
// Optional feature macro: IFU_BYPASS_EN -- when defined, a response arriving
// while the FIFO is empty is presented to the core in the same cycle.
module instruction_fetch_unit #(
    parameter int             l        = 16,
    parameter int             DEPTH    = 4,
    parameter logic [l-1:0]   RESET_PC = '0
) (
    input  logic         Clk,
    input  logic         ResetN,
    output logic         MemReqValid,
    output logic [l-1:0] MemReqAddr,
    input  logic         MemReqReady,
    input  logic         MemRespValid,
    input  logic [l-1:0] MemRespData,
    input  logic         Redirect,
    input  logic [l-1:0] RedirectPC,
    output logic         InstrValid,
    output logic [l-1:0] Instruction,
    output logic [l-1:0] InstrPC,
    input  logic         InstrReady
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t             state;
    logic [l-1:0]       fetchPc;
    logic [l-1:0]       respPc;
    logic [CNT_W-1:0]   fifoCount;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outstandingNext;
    logic [CNT_W-1:0]   dropCount;
    logic [CNT_W:0]     occupancy;
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [l-1:0]       wordMem [DEPTH];
    logic [l-1:0]       pcMem   [DEPTH];

    logic               reqFire;
    logic               doRedirect;
    logic               bufValid;
    logic               push;
    logic               pop;

    // Requests are throttled so buffered plus in-flight words never exceed the FIFO depth.
    assign occupancy       = {1'b0, fifoCount} + {1'b0, outstanding};
    assign MemReqValid     = (state == FETCH) && (occupancy < (CNT_W+1)'(DEPTH));
    assign MemReqAddr      = fetchPc;
    assign reqFire         = MemReqValid && MemReqReady;
    assign doRedirect      = Redirect && (state != IDLE);
    assign outstandingNext = outstanding + CNT_W'(reqFire) - CNT_W'(MemRespValid);
    assign bufValid        = (fifoCount != '0);

`ifdef IFU_BYPASS_EN
    logic bypass;
    assign bypass      = (fifoCount == '0) && (state == FETCH) && MemRespValid;
    assign InstrValid  = bufValid || bypass;
    assign Instruction = bufValid ? wordMem[headPtr] : (bypass ? MemRespData : '0);
    assign InstrPC     = bufValid ? pcMem[headPtr]   : (bypass ? respPc      : '0);
    assign pop         = bufValid && InstrReady;
    // A bypassed word the core takes immediately never enters the FIFO.
    assign push        = MemRespValid && (state == FETCH) && !doRedirect && !(bypass && InstrReady);
`else
    assign InstrValid  = bufValid;
    assign Instruction = bufValid ? wordMem[headPtr] : '0;
    assign InstrPC     = bufValid ? pcMem[headPtr]   : '0;
    assign pop         = bufValid && InstrReady;
    assign push        = MemRespValid && (state == FETCH) && !doRedirect;
`endif

    // FIFO occupancy and pointers; a redirect empties the buffer.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            fifoCount <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
        end else if (doRedirect) begin
            fifoCount <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + PTR_W'(1);
            if (pop)  headPtr <= headPtr + PTR_W'(1);
            fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage holds each word together with the PC it was fetched from.
    always_ff @(posedge Clk) begin
        if (push) begin
            wordMem[tailPtr] <= MemRespData;
            pcMem[tailPtr]   <= respPc;
        end
    end

    // Fetch control: state, fetch/response PCs, in-flight and drop counters.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state       <= IDLE;
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            dropCount   <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (reqFire) fetchPc <= fetchPc + l'(1);
            if (doRedirect) begin
                // Everything still in flight after this cycle is stale.
                fetchPc   <= RedirectPC;
                respPc    <= RedirectPC;
                dropCount <= outstandingNext;
                state     <= (outstandingNext != '0) ? FLUSH : FETCH;
            end else begin
                case (state)
                    IDLE: state <= FETCH;
                    FETCH: begin
                        if (MemRespValid) respPc <= respPc + l'(1);
                    end
                    FLUSH: begin
                        if (MemRespValid) begin
                            dropCount <= dropCount - CNT_W'(1);
                            if (dropCount == CNT_W'(1)) state <= FETCH;
                        end else if (dropCount == '0) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    respWithoutRequest: assert property (@(posedge Clk) disable iff (!ResetN)
        MemRespValid |-> (outstanding != '0));

    occupancyBound: assert property (@(posedge Clk) disable iff (!ResetN)
        occupancy <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-configurable memory model.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        ResetN;
    logic        MemReqValid;
    logic [15:0] MemReqAddr;
    logic        MemReqReady;
    logic        MemRespValid;
    logic [15:0] MemRespData;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        InstrValid;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;
    logic        InstrReady;

    int errors = 0;
    int checks = 0;
    int memLat = 1;

    logic        stV [4];
    logic [15:0] stD [4];

    instruction_fetch_unit #(.l(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr), .MemReqReady(MemReqReady),
        .MemRespValid(MemRespValid), .MemRespData(MemRespData),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .Instruction(Instruction), .InstrPC(InstrPC),
        .InstrReady(InstrReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // Memory model: samples the request at the falling edge, answers memLat cycles later.
    initial begin : memModel
        logic        fireN;
        logic [15:0] addrN;
        MemRespValid = 1'b0;
        MemRespData  = '0;
        for (int i = 0; i < 4; i++) begin stV[i] = 1'b0; stD[i] = '0; end
        forever begin
            @(negedge Clk);
            fireN = (ResetN === 1'b1) && MemReqValid && MemReqReady;
            addrN = MemReqAddr;
            @(posedge Clk);
            #1;
            if (ResetN !== 1'b1) begin
                for (int i = 0; i < 4; i++) begin stV[i] = 1'b0; stD[i] = '0; end
                MemRespValid = 1'b0;
                MemRespData  = '0;
            end else begin
                for (int i = 3; i > 0; i--) begin stV[i] = stV[i-1]; stD[i] = stD[i-1]; end
                stV[0] = fireN;
                stD[0] = memWord(addrN);
                MemRespValid = stV[memLat-1];
                MemRespData  = stD[memLat-1];
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset(input int lat);
        ResetN      = 1'b0;
        Redirect    = 1'b0;
        RedirectPC  = '0;
        InstrReady  = 1'b0;
        MemReqReady = 1'b0;
        memLat      = lat;
        repeat (3) @(posedge Clk);
        #1 ResetN = 1'b1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        InstrReady = 1'b0; MemReqReady = 1'b0; memLat = 1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL reset_reqvalid: got %b expected 0", MemReqValid); end
        checks++; if (MemReqAddr !== 16'h0000) begin errors++; $display("FAIL reset_reqaddr: got %h expected 0000", MemReqAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_instrvalid: got %b expected 0", InstrValid); end
        checks++; if (Instruction !== 16'h0000) begin errors++; $display("FAIL reset_instruction: got %h expected 0000", Instruction); end
        checks++; if (InstrPC !== 16'h0000) begin errors++; $display("FAIL reset_instrpc: got %h expected 0000", InstrPC); end
        @(posedge Clk);
        #1 ResetN = 1'b1;
        @(negedge Clk);
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL idle_reqvalid: got %b expected 0", MemReqValid); end
        tick();
        @(negedge Clk);
        checks++; if (MemReqValid !== 1'b1) begin errors++; $display("FAIL fetch_reqvalid: got %b expected 1", MemReqValid); end
        checks++; if (MemReqAddr !== 16'h0000) begin errors++; $display("FAIL fetch_reqaddr: got %h expected 0000", MemReqAddr); end
    endtask

    task automatic test_stream();
        int  reqN;
        int  popN;
        bit  started;
        reqN = 0; popN = 0; started = 0;
        doReset(1);
        MemReqReady = 1'b1;
        InstrReady  = 1'b1;
        for (int c = 0; c < 40 && popN < 8; c++) begin
            @(negedge Clk);
            if (MemReqValid && MemReqReady && reqN < 8) begin
                checks++;
                if (MemReqAddr !== 16'(reqN)) begin errors++; $display("FAIL stream_reqaddr: got %h expected %h", MemReqAddr, 16'(reqN)); end
                reqN++;
            end
            if (started) begin
                checks++;
                if (InstrValid !== 1'b1) begin errors++; $display("FAIL stream_gap: got InstrValid=%b expected 1", InstrValid); end
            end
            if (InstrValid === 1'b1) begin
                started = 1;
                checks++;
                if (Instruction !== 16'h1000 + 16'(popN)) begin errors++; $display("FAIL stream_data: got %h expected %h", Instruction, 16'h1000 + 16'(popN)); end
                checks++;
                if (InstrPC !== 16'(popN)) begin errors++; $display("FAIL stream_pc: got %h expected %h", InstrPC, 16'(popN)); end
                popN++;
            end
        end
        checks++;
        if (popN != 8) begin errors++; $display("FAIL stream_timeout: got %0d instructions expected 8", popN); end
    endtask

    task automatic test_backpressure();
        int reqN;
        int popN;
        bit firstReq;
        reqN = 0; popN = 0; firstReq = 1;
        doReset(1);
        MemReqReady = 1'b1;
        InstrReady  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (MemReqValid && MemReqReady) begin
                checks++;
                if (MemReqAddr !== 16'(reqN)) begin errors++; $display("FAIL bp_reqaddr: got %h expected %h", MemReqAddr, 16'(reqN)); end
                reqN++;
            end
        end
        checks++; if (reqN != 4) begin errors++; $display("FAIL bp_reqcount: got %0d expected 4", reqN); end
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL bp_reqvalid: got %b expected 0", MemReqValid); end
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL bp_instrvalid: got %b expected 1", InstrValid); end
        checks++; if (InstrPC !== 16'h0000) begin errors++; $display("FAIL bp_headpc: got %h expected 0000", InstrPC); end
        checks++; if (Instruction !== 16'h1000) begin errors++; $display("FAIL bp_headdata: got %h expected 1000", Instruction); end
        tick();
        InstrReady = 1'b1;
        for (int c = 0; c < 30 && popN < 6; c++) begin
            @(negedge Clk);
            if (MemReqValid && MemReqReady && firstReq) begin
                firstReq = 0;
                checks++;
                if (MemReqAddr !== 16'h0004) begin errors++; $display("FAIL bp_nextreq: got %h expected 0004", MemReqAddr); end
            end
            if (InstrValid === 1'b1) begin
                checks++;
                if (InstrPC !== 16'(popN)) begin errors++; $display("FAIL bp_drain_pc: got %h expected %h", InstrPC, 16'(popN)); end
                checks++;
                if (Instruction !== 16'h1000 + 16'(popN)) begin errors++; $display("FAIL bp_drain_data: got %h expected %h", Instruction, 16'h1000 + 16'(popN)); end
                popN++;
            end
        end
        checks++;
        if (popN != 6) begin errors++; $display("FAIL bp_timeout: got %0d instructions expected 6", popN); end
    endtask

    task automatic test_redirect();
        int popN;
        popN = 0;
        doReset(3);
        MemReqReady = 1'b1;
        InstrReady  = 1'b1;
        tick();
        tick();
        tick();
        MemReqReady = 1'b0;
        Redirect    = 1'b1;
        RedirectPC  = 16'h0040;
        tick();
        Redirect    = 1'b0;
        MemReqReady = 1'b1;
        @(negedge Clk);
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL redir_flush_reqvalid: got %b expected 0", MemReqValid); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL redir_flush_instrvalid: got %b expected 0", InstrValid); end
        for (int c = 0; c < 30 && popN < 2; c++) begin
            @(negedge Clk);
            if (InstrValid === 1'b1) begin
                checks++;
                if (InstrPC !== 16'h0040 + 16'(popN)) begin errors++; $display("FAIL redir_pc: got %h expected %h", InstrPC, 16'h0040 + 16'(popN)); end
                checks++;
                if (Instruction !== 16'h1040 + 16'(popN)) begin errors++; $display("FAIL redir_data: got %h expected %h", Instruction, 16'h1040 + 16'(popN)); end
                popN++;
            end
        end
        checks++;
        if (popN != 2) begin errors++; $display("FAIL redir_timeout: got %0d instructions expected 2", popN); end
    endtask

    task automatic test_wrap();
        int          reqN;
        int          popN;
        logic [15:0] expPc;
        reqN = 0; popN = 0;
        doReset(1);
        MemReqReady = 1'b1;
        InstrReady  = 1'b1;
        tick();
        Redirect   = 1'b1;
        RedirectPC = 16'hFFFF;
        tick();
        Redirect   = 1'b0;
        @(negedge Clk);
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL wrap_flush_reqvalid: got %b expected 0", MemReqValid); end
        for (int c = 0; c < 20 && popN < 2; c++) begin
            @(negedge Clk);
            if (MemReqValid && MemReqReady && reqN < 2) begin
                expPc = (reqN == 0) ? 16'hFFFF : 16'h0000;
                checks++;
                if (MemReqAddr !== expPc) begin errors++; $display("FAIL wrap_reqaddr: got %h expected %h", MemReqAddr, expPc); end
                reqN++;
            end
            if (InstrValid === 1'b1) begin
                expPc = (popN == 0) ? 16'hFFFF : 16'h0000;
                checks++;
                if (InstrPC !== expPc) begin errors++; $display("FAIL wrap_pc: got %h expected %h", InstrPC, expPc); end
                checks++;
                if (Instruction !== memWord(expPc)) begin errors++; $display("FAIL wrap_data: got %h expected %h", Instruction, memWord(expPc)); end
                popN++;
            end
        end
        checks++;
        if (popN != 2) begin errors++; $display("FAIL wrap_timeout: got %0d instructions expected 2", popN); end
    endtask

    task automatic test_req_stall();
        bit found;
        found = 0;
        doReset(1);
        MemReqReady = 1'b1;
        InstrReady  = 1'b1;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (MemReqValid === 1'b1 && MemReqAddr === 16'h0007) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL stall_timeout: got no request at 0007 expected one");
        end else begin
            MemReqReady = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge Clk);
                checks++; if (MemReqValid !== 1'b1) begin errors++; $display("FAIL stall_reqvalid: got %b expected 1", MemReqValid); end
                checks++; if (MemReqAddr !== 16'h0007) begin errors++; $display("FAIL stall_reqaddr: got %h expected 0007", MemReqAddr); end
                if (k < 4) tick();
            end
            tick();
            MemReqReady = 1'b1;
            @(negedge Clk);
            tick();
            @(negedge Clk);
            checks++; if (MemReqValid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b expected 1", MemReqValid); end
            checks++; if (MemReqAddr !== 16'h0008) begin errors++; $display("FAIL stall_next_addr: got %h expected 0008", MemReqAddr); end
        end
    endtask

    task automatic test_mid_reset();
        int reqN;
        bit seen;
        reqN = 0; seen = 0;
        doReset(3);
        MemReqReady = 1'b0;
        InstrReady  = 1'b0;
        tick();
        Redirect   = 1'b1;
        RedirectPC = 16'h0020;
        tick();
        Redirect    = 1'b0;
        MemReqReady = 1'b1;
        repeat (4) tick();
        #1;
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL mrst_pre_instrvalid: got %b expected 1", InstrValid); end
        checks++; if (InstrPC !== 16'h0020) begin errors++; $display("FAIL mrst_pre_pc: got %h expected 0020", InstrPC); end
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL mrst_pre_reqvalid: got %b expected 0", MemReqValid); end
        #1 ResetN = 1'b0;
        memLat = 1;
        #1;
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL mrst_instrvalid: got %b expected 0", InstrValid); end
        checks++; if (MemReqValid !== 1'b0) begin errors++; $display("FAIL mrst_reqvalid: got %b expected 0", MemReqValid); end
        checks++; if (MemReqAddr !== 16'h0000) begin errors++; $display("FAIL mrst_reqaddr: got %h expected 0000", MemReqAddr); end
        checks++; if (Instruction !== 16'h0000) begin errors++; $display("FAIL mrst_instruction: got %h expected 0000", Instruction); end
        repeat (3) @(posedge Clk);
        #1;
        InstrReady = 1'b1;
        ResetN     = 1'b1;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge Clk);
            if (MemReqValid && MemReqReady && reqN == 0) begin
                checks++;
                if (MemReqAddr !== 16'h0000) begin errors++; $display("FAIL mrst_first_req: got %h expected 0000", MemReqAddr); end
                reqN++;
            end
            if (InstrValid === 1'b1) begin
                seen = 1;
                checks++;
                if (InstrPC !== 16'h0000) begin errors++; $display("FAIL mrst_first_pc: got %h expected 0000", InstrPC); end
                checks++;
                if (Instruction !== 16'h1000) begin errors++; $display("FAIL mrst_first_data: got %h expected 1000", Instruction); end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mrst_timeout: got no instruction expected one"); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_req_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
